// File: rtl/respondedor_memoria_datos.sv
// respondedor_memoria_datos
// Data-memory slave for the MEM stage. Accepts one load/store at a time,
// inserts WAIT_CYCLES wait states, then performs a byte/halfword/word access
// on an internal word-organised RAM. Load data is returned already extended.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req, we, addr, wdata    request strobe (sampled while idle), store flag,
//   size, sgn               byte address, right-justified store data,
//                           access size (00 b, 01 h, 10 w, 11 illegal), sign-extend
//   busy                    high whenever the FSM is not idle
//   ack, err, rdata         one-cycle completion pulse with error flag and load data
module respondedor_memoria_datos #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  // Only the byte-offset and word-index bits are kept; the rest of the
  // address aliases by design.
  typedef struct packed {
    logic              we;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata;
    logic [1:0]        size;
    logic              sgn;
  } req_t;

  state_t     state;
  req_t       r;
  logic [3:0] cnt;

  logic [3:0][7:0] mem [DEPTH];

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  assign idx = r.addr[ADDR_W+1:2];
  assign off = r.addr[1:0];

  logic legal;
  always_comb begin
    legal = 1'b0;
    case (r.size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~off[0];
      2'b10:   legal = (off == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Store lane enables and lane data: narrow data is replicated across all
  // lanes so the enable mask alone picks the destination.
  logic [3:0]      be;
  logic [3:0][7:0] wlanes;
  always_comb begin
    be     = '0;
    wlanes = '0;
    case (r.size)
      2'b00: begin
        be[off] = 1'b1;
        wlanes  = {4{r.wdata[7:0]}};
      end
      2'b01: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{r.wdata[15:0]}};
      end
      2'b10: begin
        be     = 4'b1111;
        wlanes = r.wdata;
      end
      default: ;
    endcase
  end

  // Load path: lane select then extension.
  logic [3:0][7:0] rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     load_val;
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[off];
  assign rd_half = off[1] ? rd_word[3:2] : rd_word[1:0];

  always_comb begin
    case (r.size)
      2'b00:   load_val = {{24{r.sgn & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{r.sgn & rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // RAM is never reset; the single write happens on the ACCESS->RESP edge,
  // so an aborted store leaves memory untouched.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && legal && r.we) begin
      for (int n = 0; n < 4; n++) begin
        if (be[n]) mem[idx][n] <= wlanes[n];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      r     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            r     <= '{we: we, addr: addr[ADDR_W+1:0], wdata: wdata, size: size, sgn: sgn};
            cnt   <= 4'(WAIT_CYCLES);
            busy  <= 1'b1;
            state <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_ACCESS;
        end
        S_ACCESS: begin
          err   <= ~legal;
          rdata <= (legal && !r.we) ? load_val : 32'd0;
          ack   <= 1'b1;
          state <= S_RESP;
        end
        S_RESP: begin
          ack   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/respondedor_memoria_datos.md
# respondedor_memoria_datos

Data-memory responder for the MIPS pipeline's MEM stage. It accepts one load or store request at a time through a req/ack handshake, inserts a programmable number of wait states, and performs byte, halfword or word access on an internal word-organised RAM. Load results are returned already sign- or zero-extended. The pipeline stalls on `busy`; this block replaces the zero-latency data RAM with a realistic slave.

## Interface
Parameters:
- ADDR_W, 10, word-address width; RAM depth is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states inserted before each access; legal range 0..15.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only while busy=0.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified for byte/halfword.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- sgn  in  1  loads only: 1 sign-extends, 0 zero-extends.
- busy  out  1  high whenever state is not IDLE.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; misaligned or illegal-size request.
- rdata  out  32  load result; valid with ack.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: on req=1, latch we, addr, wdata, size and sgn; load wait counter with WAIT_CYCLES. Go to WAIT, or straight to ACCESS when WAIT_CYCLES=0.
- WAIT: counter decrements once per edge. When the counter reads 1, go to ACCESS.
- ACCESS: check alignment. Halfword requires addr[0]=0. Word requires addr[1:0]=00. size=11 is always illegal.
  - Legal store: write only the addressed lanes, little-endian (byte lane n = bits 8n+7:8n, n=addr[1:0]). Other lanes are preserved.
  - Legal load: select the lane(s), extend to 32 bits per sgn, register into rdata.
  - Illegal request: no RAM write, rdata=0, err=1.
  - Next state is RESP.
- RESP: ack=1 for exactly this cycle. err holds the ACCESS result. Next state is IDLE.
- Store completion: rdata=0.
- Word index is addr[ADDR_W+1:2]. Upper address bits are ignored, so the address wraps modulo 2^(ADDR_W+2).
- req while busy=1 is ignored and is not queued. req held high through RESP is accepted again in IDLE as a new request.
- RAM contents are not initialised and are not cleared by reset.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, ack=0, err=0, rdata=0, wait counter=0.
- Reset mid-operation aborts the transaction. A store not yet at its ACCESS edge never writes. The RAM write happens only on the ACCESS→RESP edge, so a store is atomic.
- Latency: req sampled at edge k gives busy=1 after edge k and ack=1 between edges k+W+1 and k+W+2, where W=WAIT_CYCLES. busy=0 after edge k+W+2. The earliest next acceptance is at edge k+W+3.
- Total occupancy is W+2 cycles. With W=0: ack appears after edge k+1, busy clears after edge k+2.
- rdata and err hold their values until the next ACCESS edge or reset; they are guaranteed only while ack=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst_n=0 mid-WAIT of a store to word 3. Required: busy, ack, err, rdata drop to 0 immediately. A later lw of word 3 returns the prior value.
- Word round trip, W=2: sw 0xDEADBEEF at addr 0x10 on edge 0. Required: ack after edge 3, busy clears after edge 4. lw 0x10 returns 0xDEADBEEF with err=0.
- Byte lanes: after the round trip, sb 0x80 to addr 0x12. Required: lw 0x10 returns 0xDE80BEEF. lb 0x12 returns 0xFFFFFF80. lbu 0x12 returns 0x00000080.
- Halfword: sh 0x8001 at 0x22, then lh 0x22 and lhu 0x22. Required: 0xFFFF8001 and 0x00008001; lanes 1:0 of word 8 unchanged.
- Misalignment: lw 0x11, sh 0x13, and size=11. Required for each: ack with err=1, rdata=0, RAM unchanged.
- Handshake: pulse req every cycle during a transaction. Required: exactly one ack per accepted request, and no acceptance while busy=1. Address 0x1000 with ADDR_W=10 aliases to address 0x0000.
